// File: rtl/wb_stage.sv
// Write-back stage: accepts one memory-stage result, commits it to the register
// file as a one-cycle write pulse, then holds a downstream request until acknowledged.
module wb_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_memoryed_req_i,
  output logic            wb_memoryed_ack_o,
  output logic            wb_writebacked_req_o,
  input  logic            wb_writebacked_ack_i,
  input  logic [4:0]      wb_rd_i,
  input  logic            wb_rd_wen_i,
  input  logic            wb_ren_i,
  input  logic [2:0]      wb_funct3_i,
  input  logic [2:0]      wb_addr_low_i,
  input  logic [XLEN-1:0] wb_alu_data_i,
  input  logic [XLEN-1:0] wb_mem_rdata_i,
  output logic [4:0]      wb_rd_o,
  output logic            wb_rd_wen_o,
  output logic [XLEN-1:0] wb_rd_data_o,
  output logic [63:0]     wb_retire_cnt_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COMMIT = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [4:0]      rd_q;
  logic            rd_wen_q;
  logic            ren_q;
  logic [2:0]      funct3_q;
  logic [2:0]      addr_low_q;
  logic [XLEN-1:0] alu_data_q;
  logic [XLEN-1:0] mem_rdata_q;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] result;
  logic [63:0]     retire_cnt;
  logic            accept;
  logic            busy;
  logic            retire;

  assign busy   = (state == COMMIT) || (state == WAIT);
  assign accept = wb_memoryed_req_i && wb_memoryed_ack_o;
  assign retire = busy && wb_writebacked_ack_i;

  assign wb_memoryed_ack_o    = (state == IDLE) && !rst;
  assign wb_writebacked_req_o = busy && !rst;
  assign wb_rd_wen_o          = (state == COMMIT) && !rst && rd_wen_q && (rd_q != 5'd0);
  assign wb_rd_o              = rd_q;
  assign wb_rd_data_o         = result;
  assign wb_retire_cnt_o      = retire_cnt;

  // Load alignment: the doubleword is shifted right by whole bytes, zero-filling the top.
  always_comb begin
    shifted = mem_rdata_q >> {addr_low_q, 3'b000};
    result  = alu_data_q;
    if (ren_q) begin
      case (funct3_q)
        3'b000:  result = {{56{shifted[7]}},  shifted[7:0]};
        3'b001:  result = {{48{shifted[15]}}, shifted[15:0]};
        3'b010:  result = {{32{shifted[31]}}, shifted[31:0]};
        3'b100:  result = {56'd0, shifted[7:0]};
        3'b101:  result = {48'd0, shifted[15:0]};
        3'b110:  result = {32'd0, shifted[31:0]};
        default: result = shifted;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COMMIT;
      COMMIT:  state_nxt = wb_writebacked_ack_i ? IDLE : WAIT;
      WAIT:    if (wb_writebacked_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      ren_q       <= 1'b0;
      funct3_q    <= '0;
      addr_low_q  <= '0;
      alu_data_q  <= '0;
      mem_rdata_q <= '0;
      retire_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_q        <= wb_rd_i;
        rd_wen_q    <= wb_rd_wen_i;
        ren_q       <= wb_ren_i;
        funct3_q    <= wb_funct3_i;
        addr_low_q  <= wb_addr_low_i;
        alu_data_q  <= wb_alu_data_i;
        mem_rdata_q <= wb_mem_rdata_i;
      end
      if (retire) retire_cnt <= retire_cnt + 64'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expected write-back values.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        mreq;
  logic        mack;
  logic        wreq;
  logic        wack;
  logic [4:0]  rd_i;
  logic        rd_wen_i;
  logic        ren_i;
  logic [2:0]  funct3_i;
  logic [2:0]  addr_low_i;
  logic [63:0] alu_i;
  logic [63:0] mem_i;
  logic [4:0]  rd_o;
  logic        rd_wen_o;
  logic [63:0] rd_data_o;
  logic [63:0] retire_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [63:0] exp_cnt = 64'd0;

  wb_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .wb_memoryed_req_i(mreq), .wb_memoryed_ack_o(mack),
    .wb_writebacked_req_o(wreq), .wb_writebacked_ack_i(wack),
    .wb_rd_i(rd_i), .wb_rd_wen_i(rd_wen_i), .wb_ren_i(ren_i),
    .wb_funct3_i(funct3_i), .wb_addr_low_i(addr_low_i),
    .wb_alu_data_i(alu_i), .wb_mem_rdata_i(mem_i),
    .wb_rd_o(rd_o), .wb_rd_wen_o(rd_wen_o), .wb_rd_data_o(rd_data_o),
    .wb_retire_cnt_o(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rd, input logic wen, input logic ren,
                        input logic [2:0] f3, input logic [2:0] off,
                        input logic [63:0] alu, input logic [63:0] mem);
    rd_i = rd; rd_wen_i = wen; ren_i = ren; funct3_i = f3;
    addr_low_i = off; alu_i = alu; mem_i = mem;
  endtask

  // One instruction with downstream ack held high: accept, COMMIT, back to IDLE.
  task automatic run_instr(input string tag, input logic [4:0] rd, input logic wen,
                           input logic ren, input logic [2:0] f3, input logic [2:0] off,
                           input logic [63:0] alu, input logic [63:0] mem,
                           input logic [63:0] exp_data, input logic exp_wen);
    wack = 1'b1;
    set_in(rd, wen, ren, f3, off, alu, mem);
    mreq = 1'b1;
    tick();
    mreq = 1'b0;
    set_in(5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'hDEAD, 64'hBEEF);
    check({tag, ".data"}, rd_data_o, exp_data);
    check({tag, ".wen"}, {63'd0, rd_wen_o}, {63'd0, exp_wen});
    check({tag, ".rd"}, {59'd0, rd_o}, {59'd0, rd});
    check({tag, ".req"}, {63'd0, wreq}, 64'd1);
    check({tag, ".mack"}, {63'd0, mack}, 64'd0);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    check({tag, ".idle_req"}, {63'd0, wreq}, 64'd0);
    check({tag, ".idle_wen"}, {63'd0, rd_wen_o}, 64'd0);
    check({tag, ".cnt"}, retire_cnt, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; mreq = 1'b0; wack = 1'b0;
    set_in(5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
    tick(); tick();
    check("rst.mack", {63'd0, mack}, 64'd0);
    check("rst.req", {63'd0, wreq}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst.mack_after", {63'd0, mack}, 64'd1);
    check("rst.wen", {63'd0, rd_wen_o}, 64'd0);
    check("rst.rd", {59'd0, rd_o}, 64'd0);
    check("rst.data", rd_data_o, 64'd0);
    check("rst.cnt", retire_cnt, 64'd0);

    run_instr("alu",   5'd5,  1'b1, 1'b0, 3'b000, 3'd0, 64'h1234, 64'h0, 64'h1234, 1'b1);
    run_instr("lb",    5'd7,  1'b1, 1'b1, 3'b000, 3'd3, 64'h0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    run_instr("lbu",   5'd7,  1'b1, 1'b1, 3'b100, 3'd3, 64'h0, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080, 1'b1);
    run_instr("lh",    5'd8,  1'b1, 1'b1, 3'b001, 3'd2, 64'h0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF, 1'b1);
    run_instr("lhu",   5'd8,  1'b1, 1'b1, 3'b101, 3'd2, 64'h0, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_80FF, 1'b1);
    run_instr("lw",    5'd9,  1'b1, 1'b1, 3'b010, 3'd4, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1'b1);
    run_instr("lwu",   5'd9,  1'b1, 1'b1, 3'b110, 3'd4, 64'h0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1'b1);
    run_instr("ld",    5'd10, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0, 64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000, 1'b1);
    run_instr("ld_off4", 5'd10, 1'b1, 1'b1, 3'b011, 3'd4, 64'h0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1'b1);
    run_instr("f3_111", 5'd11, 1'b1, 1'b1, 3'b111, 3'd0, 64'h0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 1'b1);
    run_instr("lb_off7", 5'd12, 1'b1, 1'b1, 3'b000, 3'd7, 64'h0, 64'h7F00_0000_0000_00FF, 64'h0000_0000_0000_007F, 1'b1);
    run_instr("x0",    5'd0,  1'b1, 1'b0, 3'b000, 3'd0, 64'h5555, 64'h0, 64'h5555, 1'b0);
    run_instr("nowen", 5'd3,  1'b0, 1'b0, 3'b000, 3'd0, 64'hAAAA, 64'h0, 64'hAAAA, 1'b0);

    // Ack while IDLE must not count.
    wack = 1'b1;
    tick(); tick();
    check("idle_ack.cnt", retire_cnt, exp_cnt);

    // Downstream stall: ack low for COMMIT + two WAIT cycles, upstream holds req.
    wack = 1'b0;
    set_in(5'd14, 1'b1, 1'b0, 3'd0, 3'd0, 64'hA1, 64'h0);
    mreq = 1'b1;
    tick();
    set_in(5'd15, 1'b1, 1'b0, 3'd0, 3'd0, 64'hB2, 64'h0);
    check("stall.c_wen", {63'd0, rd_wen_o}, 64'd1);
    check("stall.c_req", {63'd0, wreq}, 64'd1);
    check("stall.c_mack", {63'd0, mack}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall.w_wen", {63'd0, rd_wen_o}, 64'd0);
      check("stall.w_req", {63'd0, wreq}, 64'd1);
      check("stall.w_mack", {63'd0, mack}, 64'd0);
      check("stall.w_data", rd_data_o, 64'hA1);
      check("stall.w_rd", {59'd0, rd_o}, 64'd14);
    end
    tick();
    check("stall.w3_req", {63'd0, wreq}, 64'd1);
    check("stall.w3_cnt", retire_cnt, exp_cnt);
    wack = 1'b1;
    tick();
    exp_cnt = exp_cnt + 64'd1;
    check("stall.idle_req", {63'd0, wreq}, 64'd0);
    check("stall.idle_mack", {63'd0, mack}, 64'd1);
    check("stall.cnt", retire_cnt, exp_cnt);
    tick();
    mreq = 1'b0;
    check("stall.b_data", rd_data_o, 64'hB2);
    check("stall.b_wen", {63'd0, rd_wen_o}, 64'd1);
    check("stall.b_rd", {59'd0, rd_o}, 64'd15);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    check("stall.b_cnt", retire_cnt, exp_cnt);

    // Reset while in WAIT drops the pending instruction.
    wack = 1'b0;
    set_in(5'd20, 1'b1, 1'b0, 3'd0, 3'd0, 64'hC3, 64'h0);
    mreq = 1'b1;
    tick();
    mreq = 1'b0;
    tick();
    check("rstw.pre_req", {63'd0, wreq}, 64'd1);
    rst = 1'b1;
    #1;
    check("rstw.mack_in_rst", {63'd0, mack}, 64'd0);
    tick();
    check("rstw.req", {63'd0, wreq}, 64'd0);
    check("rstw.wen", {63'd0, rd_wen_o}, 64'd0);
    check("rstw.cnt", retire_cnt, 64'd0);
    check("rstw.rd", {59'd0, rd_o}, 64'd0);
    rst = 1'b0;
    #1;
    check("rstw.mack", {63'd0, mack}, 64'd1);
    tick();
    check("rstw.idle_req", {63'd0, wreq}, 64'd0);
    check("rstw.idle_wen", {63'd0, rd_wen_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage. Responder on the memoryed req/ack handshake driven by the memory stage.
- Per accepted instruction:
  - selects either the ALU result or the load data;
  - for loads, extracts, aligns and sign/zero-extends the loaded value;
  - issues a single-cycle register-file write;
  - signals completion downstream on the writebacked req/ack handshake.
- Sits between the memory stage and the register file / commit logic. Also keeps a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width in bits. Only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_memoryed_req_i  in  1  upstream request: new instruction result valid
- wb_memoryed_ack_o  out  1  upstream acknowledge: stage can accept
- wb_writebacked_req_o  out  1  downstream request: instruction written back
- wb_writebacked_ack_i  in  1  downstream acknowledge
- wb_rd_i  in  5  destination register index
- wb_rd_wen_i  in  1  instruction writes rd
- wb_ren_i  in  1  instruction is a load
- wb_funct3_i  in  3  load width/sign code
- wb_addr_low_i  in  3  byte offset of the load address, bits [2:0]
- wb_alu_data_i  in  XLEN  ALU/execute result
- wb_mem_rdata_i  in  XLEN  raw 64-bit aligned doubleword read from memory
- wb_rd_o  out  5  register-file write index
- wb_rd_wen_o  out  1  register-file write enable, one-cycle pulse
- wb_rd_data_o  out  XLEN  register-file write data
- wb_retire_cnt_o  out  64  count of completed downstream handshakes

Behaviour:
- Reset values (while rst is high): state IDLE; all latched registers 0; wb_writebacked_req_o=0; wb_rd_wen_o=0; wb_rd_o=0; wb_rd_data_o=0; wb_retire_cnt_o=0.
- States: IDLE, COMMIT, WAIT.
- wb_memoryed_ack_o = 1 iff state==IDLE and rst==0. This output is combinational from state.
- Accept occurs when wb_memoryed_req_i & wb_memoryed_ack_o at a posedge.
  - On accept, latch rd, rd_wen, ren, funct3, addr_low, alu_data and mem_rdata.
  - Move to COMMIT.
- Result computation, combinational from the latched values:
  - ren=0: result = alu_data.
  - ren=1: shifted = mem_rdata >> (addr_low*8). Then select by funct3:
    - 000 LB: sext of shifted[7:0]
    - 001 LH: sext of shifted[15:0]
    - 010 LW: sext of shifted[31:0]
    - 011 LD: shifted
    - 100 LBU: zext of shifted[7:0]
    - 101 LHU: zext of shifted[15:0]
    - 110 LWU: zext of shifted[31:0]
    - 111: treated as LD
  - Misaligned offsets are not trapped. Bytes shifted in beyond bit 63 are zero.
- COMMIT state (exactly one cycle per instruction):
  - wb_rd_wen_o = latched rd_wen & (rd != 0). Writes to x0 are suppressed.
  - wb_rd_o = latched rd; wb_rd_data_o = result.
  - wb_writebacked_req_o = 1.
  - If wb_writebacked_ack_i is high this cycle: increment retire count, next state IDLE. Otherwise next state WAIT.
- WAIT state:
  - wb_writebacked_req_o stays 1; wb_rd_wen_o = 0, so there is no repeated write.
  - wb_rd_o and wb_rd_data_o hold their values.
  - On wb_writebacked_ack_i: increment retire count, next state IDLE.
- Throughput: at most one instruction every 2 cycles (accept, then COMMIT with immediate ack). Latency is 1 cycle from accept edge to the register-file write.
- Upstream req while state != IDLE: ignored, because ack_o=0. Upstream must hold req.
- wb_writebacked_ack_i while IDLE: ignored; no count change.
- wb_retire_cnt_o is 64 bits and wraps from 2^64-1 to 0.
- Reset asserted mid-operation (COMMIT or WAIT): the next state is IDLE with all outputs at reset values. The pending instruction is dropped and not counted.
- wb_rd_wen_o is asserted only in the COMMIT state.

Test Plan:
- Reset, then an ALU instruction: rd=5, rd_wen=1, ren=0, alu_data=0x1234 with downstream ack tied high -> one cycle after accept, wb_rd_wen_o=1, wb_rd_o=5, wb_rd_data_o=0x1234, req_o=1; IDLE next cycle; retire_cnt=1.
- LB at offset 3: mem_rdata=0x0000_0000_80FF_0000, funct3=000 -> result 0xFFFF_FFFF_FFFF_FF80. Same input with funct3=100 (LBU) -> 0x80.
- LW/LWU at offset 4: mem_rdata=0x8765_4321_0000_0000 -> LW gives 0xFFFF_FFFF_8765_4321; LWU gives 0x8765_4321. LD at offset 0 gives the raw value.
- rd=0 with rd_wen=1 -> wb_rd_wen_o stays 0; req_o still asserted; retire_cnt still increments.
- Downstream ack held low for 3 cycles -> wb_rd_wen_o high exactly one cycle; req_o high for 4 cycles; memoryed_ack_o low throughout; upstream req held during the stall is accepted only after return to IDLE.
- rst asserted while in WAIT -> next cycle req_o=0, ack_o=1, retire_cnt=0, no write pulse.
